// File: rtl/img_op_sched.sv
// img_op_sched: round-robin scheduler for image engines sharing one ping-pong
// pixel-memory pair. Latches requests, grants one engine at a time, issues its
// start pulse, follows its done handshake and flips the buffer select after
// every completed op.
// Optional feature: define SCHED_TIMEOUT_EN to enable the WAIT_ACK/RUN watchdog.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | no owner; arbitrate over pending|req
//  START    | eng_start[owner] high this cycle; watchdog cleared
//  WAIT_ACK | waiting for owner to drop eng_done (engine accepted)
//  RUN      | owner busy; its write strobe reaches memory
//  SWAP     | toggle buf_sel, pulse op_done, release owner
module img_op_sched #(
    parameter int N_ENG   = 3,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 2047
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_ENG-1:0]        req,
    input  logic [N_ENG-1:0]        eng_done,
    input  logic [N_ENG*ADDR_W-1:0] eng_rd_adrr,
    input  logic [N_ENG*ADDR_W-1:0] eng_wr_adrr,
    input  logic [N_ENG-1:0]        eng_wr_en,
    output logic [N_ENG-1:0]        eng_start,
    output logic [N_ENG-1:0]        grant,
    output logic [ADDR_W-1:0]       mem_rd_adrr,
    output logic [ADDR_W-1:0]       mem_wr_adrr,
    output logic                    mem_wr_en,
    output logic                    buf_sel,
    output logic                    busy,
    output logic                    op_done,
    output logic                    err_timeout
);

    localparam int IDX_W = $clog2(N_ENG);

    typedef enum logic [2:0] {IDLE, START, WAIT_ACK, RUN, SWAP} state_t;

    state_t             state, state_n;
    logic [N_ENG-1:0]   pending, pending_n;
    logic [N_ENG-1:0]   grant_n, start_n, clr;
    logic [N_ENG-1:0]   pick_vec;
    logic [IDX_W-1:0]   last, last_n, win;
    logic               found;
    logic               buf_n, op_done_n;
    logic               owner_done, owner_wr_en;
    logic               to_hit, abort;

    // Round-robin search starting just after the last owner, wrapping.
    always_comb begin
        pick_vec = pending | req;
        found    = 1'b0;
        win      = '0;
        for (int k = 1; k <= N_ENG; k++) begin
            if (!found && pick_vec[(int'(last) + k) % N_ENG]) begin
                found = 1'b1;
                win   = IDX_W'((int'(last) + k) % N_ENG);
            end
        end
    end

    // Grant-selected memory mux and owner handshake; zero when grant is empty.
    always_comb begin
        mem_rd_adrr = '0;
        mem_wr_adrr = '0;
        owner_done  = 1'b0;
        owner_wr_en = 1'b0;
        for (int i = 0; i < N_ENG; i++) begin
            if (grant[i]) begin
                mem_rd_adrr = mem_rd_adrr | eng_rd_adrr[i*ADDR_W +: ADDR_W];
                mem_wr_adrr = mem_wr_adrr | eng_wr_adrr[i*ADDR_W +: ADDR_W];
                owner_done  = owner_done  | eng_done[i];
                owner_wr_en = owner_wr_en | eng_wr_en[i];
            end
        end
    end

    assign mem_wr_en = owner_wr_en & (state == RUN);
    assign busy      = (state != IDLE);
    assign abort     = to_hit & ((state == WAIT_ACK) | (state == RUN));

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    assign to_hit      = (wd_cnt == CNT_W'(TIMEOUT));
    assign err_timeout = err_q;

    // Saturating watchdog over WAIT_ACK/RUN; sticky error until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == START)
                wd_cnt <= '0;
            else if (((state == WAIT_ACK) || (state == RUN)) && !to_hit)
                wd_cnt <= wd_cnt + 1'b1;
            if (abort)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT >= 4);
    assign to_hit         = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_n   = state;
        grant_n   = grant;
        start_n   = '0;
        buf_n     = buf_sel;
        op_done_n = 1'b0;
        last_n    = last;
        clr       = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_n = N_ENG'(1) << win;
                    start_n = N_ENG'(1) << win;
                    last_n  = win;
                    state_n = START;
                end
            end
            START: begin
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (abort) begin
                    clr     = grant;
                    grant_n = '0;
                    state_n = IDLE;
                end else if (!owner_done) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    clr     = grant;
                    grant_n = '0;
                    state_n = IDLE;
                end else if (owner_done) begin
                    state_n = SWAP;
                end
            end
            SWAP: begin
                buf_n     = ~buf_sel;
                op_done_n = 1'b1;
                clr       = grant;
                grant_n   = '0;
                state_n   = IDLE;
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
        // A request arriving in the clearing cycle keeps the engine pending.
        pending_n = (pending & ~clr) | req;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            eng_start <= '0;
            buf_sel   <= 1'b0;
            op_done   <= 1'b0;
            pending   <= '0;
            last      <= IDX_W'(N_ENG - 1);
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            eng_start <= start_n;
            buf_sel   <= buf_n;
            op_done   <= op_done_n;
            pending   <= pending_n;
            last      <= last_n;
        end
    end

endmodule

// File: tb/tb_img_op_sched.sv
// tb_img_op_sched: directed and randomized checks of img_op_sched against a
// transaction-level model (request set, round-robin order, engine timelines).
module tb_img_op_sched;

    localparam int N  = 3;
    localparam int AW = 10;
    localparam int RW = N * AW;
`ifdef SCHED_TIMEOUT_EN
    localparam int TO   = 16;
    localparam int LOW1 = 10;
`else
    localparam int TO   = 2047;
    localparam int LOW1 = 20;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, eng_done, eng_wr_en;
    logic [RW-1:0] eng_rd_adrr, eng_wr_adrr;
    logic [N-1:0]  eng_start, grant;
    logic [AW-1:0] mem_rd_adrr, mem_wr_adrr;
    logic          mem_wr_en, buf_sel, busy, op_done, err_timeout;

    img_op_sched #(.N_ENG(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .eng_done(eng_done),
        .eng_rd_adrr(eng_rd_adrr), .eng_wr_adrr(eng_wr_adrr), .eng_wr_en(eng_wr_en),
        .eng_start(eng_start), .grant(grant), .mem_rd_adrr(mem_rd_adrr),
        .mem_wr_adrr(mem_wr_adrr), .mem_wr_en(mem_wr_en), .buf_sel(buf_sel),
        .busy(busy), .op_done(op_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // model state
    logic [N-1:0] pend, req_prev;
    int  last, owner, cyc;
    bit  active, idle_prev, rst_prev, mbuf;
    int  t_start, t_drop, t_e, t_rise;
    int  served[$];
    // stimulus knobs
    int  drop_fixed, low_fixed, req_pct;
    bit  noise, fix_addr;
    int  code, el;
    bit  seen_od;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int from);
        for (int k = 1; k <= N; k++)
            if (v[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    // One clock: check outputs against the model, then drive the next inputs.
    task automatic step(input logic [N-1:0] req_in, input bit rst_in);
        logic [N-1:0] exp_start, r, d;
        bit exp_od, exp_wen;
        int w;
        @(posedge clk);
        #1;
        exp_start = '0;
        if (rst_prev) begin
            pend = '0; last = N - 1; active = 0; mbuf = 0;
        end else if (idle_prev && pend != '0) begin
            w = pick(pend, last);
            exp_start = N'(1) << w;
            active = 1; owner = w; last = w; t_start = cyc;
            served.push_back(w);
            t_drop = cyc + ((drop_fixed >= 0) ? drop_fixed : int'($urandom_range(0, 2)));
            t_e    = (t_drop + 1 > cyc + 2) ? t_drop + 1 : cyc + 2;
            t_rise = (low_fixed >= 0) ? t_drop + low_fixed : t_e + int'($urandom_range(0, 6));
        end
        exp_od = !rst_prev && active && (cyc == t_rise + 2);
        if (exp_od) begin
            mbuf   = ~mbuf;
            pend   = pend & ~((N'(1) << owner) & ~req_prev);
            active = 0;
        end
        exp_wen = active && cyc >= t_e && cyc <= t_rise && eng_wr_en[owner];
        chk("eng_start", eng_start, exp_start);
        chk("op_done", op_done, exp_od);
        chk("buf_sel", buf_sel, mbuf);
        chk("grant", grant, active ? (N'(1) << owner) : '0);
        chk("busy", busy, active);
        chk("mem_rd", mem_rd_adrr, active ? eng_rd_adrr[owner*AW +: AW] : '0);
        chk("mem_wr", mem_wr_adrr, active ? eng_wr_adrr[owner*AW +: AW] : '0);
        chk("mem_wr_en", mem_wr_en, exp_wen);
        chk("err_timeout", err_timeout, 1'b0);
        idle_prev = !active;
        rst_prev  = rst_in;

        r = req_in;
        for (int i = 0; i < N; i++)
            if (req_pct > 0 && int'($urandom_range(0, 99)) < req_pct) r[i] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (active && i == owner) d[i] = (cyc >= t_drop && cyc < t_rise) ? 1'b0 : 1'b1;
            else                      d[i] = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        rst      = rst_in;
        req      = r;
        pend     = pend | r;
        req_prev = r;
        eng_done = d;
        if (fix_addr) begin
            eng_rd_adrr = {AW'(37), AW'(999), AW'(999)};
            eng_wr_adrr = {AW'(12), AW'(999), AW'(999)};
            eng_wr_en   = '1;
        end else begin
            eng_rd_adrr = RW'($urandom);
            eng_wr_adrr = RW'($urandom);
            eng_wr_en   = N'($urandom);
        end
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && (active || pend != '0); k++) step('0, 0);
        chk("drained", {31'd0, active || pend != '0}, 0);
    endtask

    function automatic int order_code();
        int c = 1;
        foreach (served[i]) c = c * 10 + served[i];
        return c;
    endfunction

    initial begin
        rst = 1'b1; req = '0; eng_done = '1; eng_wr_en = '0;
        eng_rd_adrr = '0; eng_wr_adrr = '0;
        pend = '0; req_prev = '0; last = N - 1; owner = 0; cyc = 0;
        active = 0; idle_prev = 1; rst_prev = 1; mbuf = 0;
        t_start = 0; t_drop = 0; t_e = 0; t_rise = 0;
        drop_fixed = -1; low_fixed = -1; req_pct = 0; noise = 0; fix_addr = 0;

        // reset, then single op on engine 1
        repeat (3) step('0, 1);
        step('0, 0);
        chk("reset_grant", grant, 0);
        chk("reset_buf", buf_sel, 0);
        drop_fixed = 2; low_fixed = LOW1;
        step(3'b010, 0);
        step('0, 0);
        chk("t1_start", eng_start, 3'b010);
        step('0, 0);
        chk("t1_start_once", eng_start, 0);
        for (int k = 0; k < 60 && active; k++) step('0, 0);
        chk("t1_finished", active, 0);
        chk("t1_buf", buf_sel, 1);
        step('0, 0);
        chk("t1_idle", busy, 0);
        drop_fixed = -1; low_fixed = -1;

        // contention: all three at once
        step('0, 1); step('0, 0);
        served.delete();
        step(3'b111, 0);
        drain();
        chk("t2_count", served.size(), 3);
        chk("t2_order", order_code(), 1012);
        chk("t2_buf", buf_sel, 1);

        // fairness: 0 re-requests through its own op, 1 still pending
        step('0, 1); step('0, 0);
        served.delete();
        step(3'b011, 0);
        step(3'b001, 0);
        for (int k = 0; k < 60 && active && owner == 0; k++) step(3'b001, 0);
        drain();
        chk("t3_order", order_code(), 1010);

        // mux: engine 2 running, others driving 999
        step('0, 1); step('0, 0);
        fix_addr = 1;
        step(3'b100, 0);
        for (int k = 0; k < 40 && !(active && cyc - 1 >= t_e); k++) step('0, 0);
        chk("t4_rd", mem_rd_adrr, 37);
        chk("t4_wr", mem_wr_adrr, 12);
        chk("t4_wen", mem_wr_en, 1);
        drain();
        step('0, 0);
        chk("t4_idle_rd", mem_rd_adrr, 0);
        chk("t4_idle_wen", mem_wr_en, 0);
        fix_addr = 0;

        // reset mid-RUN with another engine pending
        step(3'b001, 0);
        for (int k = 0; k < 40 && !(active && cyc - 1 >= t_e); k++) step('0, 0);
        step(3'b010, 0);
        step('0, 1);
        step('0, 0);
        chk("t6_grant", grant, 0);
        chk("t6_buf", buf_sel, 0);
        chk("t6_busy", busy, 0);
        repeat (3) step('0, 0);
        chk("t6_no_resume", eng_start, 0);

        // randomized traffic with noise on idle engines
        step('0, 1); step('0, 0);
        noise = 1; req_pct = 12;
        repeat (1500) step('0, 0);
        req_pct = 0;
        drain();
        noise = 0;

`ifdef SCHED_TIMEOUT_EN
        // watchdog: engine 0 never acknowledges
        step('0, 1); step('0, 0);
        req = 3'b001; eng_done = '1;
        @(posedge clk); #1; req = '0;
        @(posedge clk); #1;
        chk("to_start", eng_start, 3'b001);
        el = 0; seen_od = 0;
        while (!err_timeout && el < 60) begin
            @(posedge clk); #1;
            el++;
            if (op_done) seen_od = 1;
        end
        chk("to_err", err_timeout, 1);
        chk("to_window", {31'd0, el >= 16 && el <= 18}, 1);
        chk("to_no_opdone", seen_od, 0);
        chk("to_buf", buf_sel, 0);
        chk("to_grant", grant, 0);
        req = 3'b010;
        @(posedge clk); #1; req = '0;
        @(posedge clk); #1;
        chk("to_next_start", eng_start, 3'b010);
        chk("to_sticky", err_timeout, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("to_rst_clear", err_timeout, 0);
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
